// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing generator. Pulls RGB pixels from a valid/ready
//            stream and emits {R,G,B,DE,HSYNC,VSYNC} for the HDMI encoder.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [26:0] dd1,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT  = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_ON  = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_OFF = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT  = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_ON  = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_OFF = c_VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic [26:0]     r_dd1;
    logic            r_frame_start;
    logic            r_underflow;

    logic            w_run;
    logic            w_active;
    logic            w_hsync;
    logic            w_vsync;
    logic            w_line_end;
    logic            w_frame_end;
    logic [23:0]     w_rgb;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_active    = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign w_hsync     = (r_hcnt >= c_HS_ON) && (r_hcnt < c_HS_OFF);
    // VSYNC edges are aligned to the HSYNC leading edge of the boundary lines
    assign w_vsync     = ((r_vcnt == c_VS_ON) && (r_hcnt >= c_HS_ON)) ||
                         ((r_vcnt > c_VS_ON) && (r_vcnt < c_VS_OFF)) ||
                         ((r_vcnt == c_VS_OFF) && (r_hcnt < c_HS_ON));
    assign w_line_end  = (r_hcnt == c_H_LAST);
    assign w_frame_end = w_line_end && (r_vcnt == c_V_LAST);
    assign w_rgb       = (w_active && pix_valid) ? pix_data : 24'h000000;

    assign pix_ready   = w_run && w_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_hcnt <= '0;
                    r_vcnt <= '0;
                    if (enable) begin
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (w_frame_end) begin
                        r_hcnt <= '0;
                        r_vcnt <= '0;
                        if (!enable) begin
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_line_end) begin
                        r_hcnt <= '0;
                        r_vcnt <= r_vcnt + c_VW'(1);
                    end else begin
                        r_hcnt <= r_hcnt + c_HW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dd1         <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_dd1         <= w_run ? {w_rgb, w_active, w_hsync, w_vsync} : 27'd0;
            r_frame_start <= w_run && (r_hcnt == '0) && (r_vcnt == '0);
            // A missed slot takes priority over a clear in the same cycle
            if (pix_ready && !pix_valid) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign dd1         = r_dd1;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Self-checking bench for video_timing_gen with a frame-position
//            reference model and directed plus randomized stimulus.
// Revision : 1.0
// ============================================================================
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 4;
    localparam int VA = 4, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    // VSYNC spans a linear window of the frame, starting at an HSYNC edge
    localparam int VS_ON  = (VA + VF) * HT + HA + HF;
    localparam int VS_OFF = VS_ON + VS * HT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] pix_data = 24'h0;
    logic        pix_valid = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        pix_ready;
    logic [26:0] dd1;
    logic        frame_start;
    logic        underflow;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .dd1          (dd1),
        .frame_start  (frame_start),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: run flag plus linear position within the frame
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [26:0] m_dd1 = 27'd0;
    bit          m_fs  = 1'b0;
    bit          m_uf  = 1'b0;
    logic [23:0] src_val = 24'h0;
    bit          data_rand = 1'b0;

    function automatic bit is_active(input int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic logic [26:0] exp_word(input int p, input bit v, input logic [23:0] d);
        int h;
        bit de, hsy, vsy;
        h   = p % HT;
        de  = is_active(p);
        hsy = (h >= HA + HF) && (h < HA + HF + HS);
        vsy = (p >= VS_ON) && (p < VS_OFF);
        return {(de && v) ? d : 24'h0, de, hsy, vsy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_run = 1'b0; m_pos = 0; m_dd1 = 27'd0; m_fs = 1'b0; m_uf = 1'b0;
        end else begin
            bit rdy;
            rdy   = m_run && is_active(m_pos);
            m_dd1 = m_run ? exp_word(m_pos, pix_valid, pix_data) : 27'd0;
            m_fs  = m_run && (m_pos == 0);
            if (rdy && !pix_valid) m_uf = 1'b1;
            else if (underflow_clr) m_uf = 1'b0;
            if (rdy && pix_valid) src_val = data_rand ? 24'($urandom) : src_val + 24'd1;
            if (!m_run || m_pos == FRAME - 1) begin
                m_run = enable;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("dd1", 32'(dd1), 32'(m_dd1));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("pix_ready", 32'(pix_ready), 32'(m_run && is_active(m_pos)));
    end

    task automatic step(input bit en, input bit v, input bit clr);
        @(negedge clk);
        enable        = en;
        pix_valid     = v;
        underflow_clr = clr;
        pix_data      = v ? src_val : 24'($urandom);
    endtask

    task automatic wait_pos(input int p, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (m_run && m_pos == p) hit = 1'b1;
        end
        if (!hit) begin
            n_checks++;
            $display("FAIL %s: position %0d not reached, got timeout", nm, p);
        end
    endtask

    initial begin
        logic [26:0] cap [FRAME];
        int found, xfer, de_n, hs_n, vs_n, vs_first, fs_n;
        logic [23:0] held;
        bit cur_en;

        #1 rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("reset_dd1", 32'(dd1), 32'd0);
        chk("reset_ready", 32'(pix_ready), 32'd0);
        chk("reset_fs", 32'(frame_start), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);
        rst = 1'b0;

        // Basic frame with incrementing data
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (frame_start) found = 1;
        end
        chk("first_frame_start", 32'(found), 32'd1);
        cap[0] = dd1;
        xfer = int'(pix_ready);
        for (int i = 1; i < FRAME; i++) begin
            step(1'b1, 1'b1, 1'b0);
            cap[i] = dd1;
            xfer += int'(pix_ready);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("frame_period", 32'(frame_start), 32'd1);
        de_n = 0; hs_n = 0; vs_n = 0; vs_first = -1;
        for (int i = 0; i < FRAME; i++) begin
            de_n += int'(cap[i][2]);
            hs_n += int'(cap[i][1]);
            vs_n += int'(cap[i][0]);
            if (cap[i][0] && vs_first < 0) vs_first = i;
        end
        chk("transfers", 32'(xfer), 32'd32);
        chk("de_count", 32'(de_n), 32'd32);
        chk("hsync_count", 32'(hs_n), 32'd27);
        chk("hsync_line0", 32'({cap[9][1], cap[10][1], cap[11][1], cap[12][1], cap[13][1]}), 32'b01110);
        for (int i = 0; i < HA; i++) chk("line0_pixel", 32'(cap[i][26:2]), 32'({24'(i), 1'b1}));
        chk("line3_pixel7", 32'(cap[3 * HT + 7][26:2]), 32'({24'd31, 1'b1}));
        chk("vsync_rise", 32'(vs_first), 32'(5 * HT + 10));
        chk("vsync_len", 32'(vs_n), 32'd34);

        // Single lost slot at (3,1)
        wait_pos(HT + 3, "underflow_slot");
        pix_valid = 1'b0;
        pix_data  = 24'hA5A5A5;
        held      = src_val;
        chk("held_value", 32'(held), 32'd43);
        step(1'b1, 1'b1, 1'b0);
        chk("underflow_black", 32'(dd1[26:2]), 32'({24'h0, 1'b1}));
        chk("underflow_set", 32'(underflow), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        chk("held_pixel", 32'(dd1[26:2]), 32'({held, 1'b1}));
        chk("underflow_sticky", 32'(underflow), 32'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("underflow_clr", 32'(underflow), 32'd0);

        // Enable dropped mid-frame
        wait_pos(2 * HT + 5, "enable_drop");
        enable = 1'b0;
        de_n = 0; hs_n = 0; fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 1'b1, 1'b0);
            de_n += int'(dd1[2]);
            hs_n += int'(dd1[1]);
            fs_n += int'(frame_start);
        end
        chk("stop_de_tail", 32'(de_n), 32'd11);
        chk("stop_hsync_tail", 32'(hs_n), 32'd21);
        chk("stop_no_fs", 32'(fs_n), 32'd0);
        chk("stop_ready", 32'(pix_ready), 32'd0);
        chk("stop_dd1", 32'(dd1), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("reenable_wait", 32'(frame_start), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("reenable_fs", 32'(frame_start), 32'd1);
        chk("reenable_de", 32'(dd1[2]), 32'd1);

        // Asynchronous reset at (4,1)
        wait_pos(HT + 1, "rst_setup");
        pix_valid = 1'b0;
        wait_pos(HT + 4, "rst_point");
        chk("pre_rst_ready", 32'(pix_ready), 32'd1);
        chk("pre_rst_underflow", 32'(underflow), 32'd1);
        chk("pre_rst_de", 32'(dd1[2]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_dd1", 32'(dd1), 32'd0);
        chk("async_ready", 32'(pix_ready), 32'd0);
        chk("async_underflow", 32'(underflow), 32'd0);
        chk("async_fs", 32'(frame_start), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_wait", 32'(frame_start), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_fs", 32'(frame_start), 32'd1);
        chk("post_rst_de", 32'(dd1[2]), 32'd1);

        // Randomized traffic against the model
        data_rand = 1'b1;
        cur_en    = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 149) == 0) cur_en = !cur_en;
            step(cur_en, ($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
